// File: rtl/cipher_apb_pkg.sv
// Shared definitions for the APB cipher queue controller: register addresses,
// CTRL/STATUS bit positions and the sequencer state type.
package cipher_apb_pkg;

    localparam int unsigned ADDR_CTRL   = 32'h00;
    localparam int unsigned ADDR_STATUS = 32'h04;
    localparam int unsigned ADDR_DIN    = 32'h08;
    localparam int unsigned ADDR_DOUT   = 32'h0C;
    localparam int unsigned ADDR_START  = 32'h10;
    localparam int unsigned ADDR_IRQ    = 32'h14;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_AUTO  = 1;
    localparam int unsigned CTRL_FLUSH = 2;

    localparam int unsigned STAT_BUSY      = 16;
    localparam int unsigned STAT_ABORT     = 17;
    localparam int unsigned STAT_CORE_BUSY = 18;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_REQ,
        SEQ_WAIT,
        SEQ_ACK
    } seq_state_t;

endpackage

// File: rtl/cipher_blk_fifo.sv
// Synchronous block FIFO with flush; a push into a full FIFO is taken only
// when a pop happens in the same cycle.
module cipher_blk_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_cipher_queue_ctrl.sv
// APB slave front end for a block-cipher core: input/output block FIFOs plus a
// req/ack sequencer. Define CIPHER_QUEUE_IRQ_EN to add irq_o and IRQ_MASK (0x14).
module apb_cipher_queue_ctrl
    import cipher_apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned BLOCK_W        = 128,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
    input  logic                      apb_pwrite_i,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o,
    output logic                      core_rstn_o,
    output logic                      core_req_o,
    output logic                      core_ack_o,
    output logic [BLOCK_W-1:0]        core_data_o,
    input  logic                      core_busy_i,
    input  logic                      core_valid_i,
    input  logic [BLOCK_W-1:0]        core_data_i
`ifdef CIPHER_QUEUE_IRQ_EN
    ,
    output logic                      irq_o
`endif
);

    localparam int unsigned WORDS = BLOCK_W / 32;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    seq_state_t         state, state_next;
    logic               en, auto_mode, flush_q, abort, start_pend, discard;
    logic [BLOCK_W-1:0] hold, din_buf, din_block, in_dout, out_dout;
    logic [IW-1:0]      din_idx, dout_idx;
    logic               din_last, dout_last;
    logic [CW-1:0]      in_count, out_count;
    logic               in_full, in_empty, out_full, out_empty;
    logic               access, err, wr_ok, rd_ok;
    logic               sel_ctrl, sel_status, sel_din, sel_dout, sel_start;
    logic [31:0]        rdata, status_word, out_word;
    logic               launch, abort_set, out_push, din_push, out_pop;

    assign access       = apb_psel_i & apb_penable_i;
    assign apb_pready_o = access;

    assign sel_ctrl   = (apb_paddr_i == APB_ADDR_WIDTH'(ADDR_CTRL));
    assign sel_status = (apb_paddr_i == APB_ADDR_WIDTH'(ADDR_STATUS));
    assign sel_din    = (apb_paddr_i == APB_ADDR_WIDTH'(ADDR_DIN));
    assign sel_dout   = (apb_paddr_i == APB_ADDR_WIDTH'(ADDR_DOUT));
    assign sel_start  = (apb_paddr_i == APB_ADDR_WIDTH'(ADDR_START));

    assign din_last  = (din_idx == IW'(WORDS - 1));
    assign dout_last = (dout_idx == IW'(WORDS - 1));
    assign out_word  = out_dout[32*dout_idx +: 32];

    assign status_word = {13'b0, core_busy_i, abort, (state != SEQ_IDLE),
                          8'(out_count), 8'(in_count)};

    // The final DIN word goes straight into the pushed block, not via din_buf.
    always_comb begin
        din_block = din_buf;
        din_block[(WORDS-1)*32 +: 32] = apb_pwdata_i;
    end

`ifdef CIPHER_QUEUE_IRQ_EN
    logic       sel_irq;
    logic [1:0] irq_mask;
    assign sel_irq = (apb_paddr_i == APB_ADDR_WIDTH'(ADDR_IRQ));
`endif

    always_comb begin
        err   = 1'b0;
        rdata = '0;
        if (access) begin
            if (sel_ctrl) begin
                rdata = {29'b0, flush_q, auto_mode, en};
            end else if (sel_status) begin
                if (apb_pwrite_i && !apb_pwdata_i[STAT_ABORT]) begin
                    err = 1'b1;
                end else begin
                    rdata = status_word;
                end
            end else if (sel_din) begin
                err = !apb_pwrite_i || in_full;
            end else if (sel_dout) begin
                if (apb_pwrite_i || out_empty) begin
                    err = 1'b1;
                end else begin
                    rdata = out_word;
                end
            end else if (sel_start) begin
                err = !apb_pwrite_i;
`ifdef CIPHER_QUEUE_IRQ_EN
            end else if (sel_irq) begin
                rdata = {30'b0, irq_mask};
`endif
            end else begin
                err = 1'b1;
            end
        end
    end

    assign apb_prdata_o  = rdata;
    assign apb_pslverr_o = err;

    assign wr_ok    = access && !err && apb_pwrite_i;
    assign rd_ok    = access && !err && !apb_pwrite_i;
    assign din_push = wr_ok && sel_din && din_last;
    assign out_pop  = rd_ok && sel_dout && dout_last;

    cipher_blk_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) in_fifo (
        .clk   (clk_i),
        .rstn  (rstn_i),
        .push  (din_push),
        .pop   (launch),
        .flush (flush_q),
        .din   (din_block),
        .dout  (in_dout),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    cipher_blk_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) out_fifo (
        .clk   (clk_i),
        .rstn  (rstn_i),
        .push  (out_push),
        .pop   (out_pop),
        .flush (flush_q),
        .din   (core_data_i),
        .dout  (out_dout),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    // Launch is held off during a flush cycle so nothing is popped from a FIFO being cleared.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        abort_set  = 1'b0;
        core_req_o = 1'b0;
        core_ack_o = 1'b0;
        out_push   = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (en && !in_empty && !out_full && (auto_mode || start_pend) && !flush_q) begin
                    launch     = 1'b1;
                    state_next = SEQ_REQ;
                end
            end
            SEQ_REQ: begin
                core_req_o = 1'b1;
                state_next = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (core_valid_i) begin
                    state_next = SEQ_ACK;
                end
            end
            SEQ_ACK: begin
                core_ack_o = 1'b1;
                out_push   = en && !discard;
                state_next = SEQ_IDLE;
            end
            default: state_next = SEQ_IDLE;
        endcase
        if (!en && state != SEQ_IDLE) begin
            abort_set  = 1'b1;
            state_next = SEQ_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state      <= SEQ_IDLE;
            en         <= 1'b0;
            auto_mode  <= 1'b0;
            flush_q    <= 1'b0;
            abort      <= 1'b0;
            start_pend <= 1'b0;
            discard    <= 1'b0;
            hold       <= '0;
            din_buf    <= '0;
            din_idx    <= '0;
            dout_idx   <= '0;
        end else begin
            state   <= state_next;
            flush_q <= 1'b0;
            if (wr_ok && sel_ctrl) begin
                en        <= apb_pwdata_i[CTRL_EN];
                auto_mode <= apb_pwdata_i[CTRL_AUTO];
                flush_q   <= apb_pwdata_i[CTRL_FLUSH];
            end
            if (abort_set) begin
                abort <= 1'b1;
            end else if (wr_ok && sel_status) begin
                abort <= 1'b0;
            end
            if (wr_ok && sel_start && apb_pwdata_i[0]) begin
                start_pend <= 1'b1;
            end else if (launch) begin
                start_pend <= 1'b0;
            end
            if (launch) begin
                hold    <= in_dout;
                discard <= 1'b0;
            end else if (flush_q && state != SEQ_IDLE) begin
                discard <= 1'b1;
            end
            if (flush_q) begin
                din_idx <= '0;
            end else if (wr_ok && sel_din) begin
                din_buf[32*din_idx +: 32] <= apb_pwdata_i;
                din_idx <= din_last ? '0 : din_idx + 1'b1;
            end
            if (flush_q) begin
                dout_idx <= '0;
            end else if (rd_ok && sel_dout) begin
                dout_idx <= dout_last ? '0 : dout_idx + 1'b1;
            end
        end
    end

`ifdef CIPHER_QUEUE_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            irq_mask <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_ok && sel_irq) begin
                irq_mask <= apb_pwdata_i[1:0];
            end
            irq_o <= |(irq_mask & {in_empty, !out_empty});
        end
    end
`endif

    assign core_rstn_o = en;
    assign core_data_o = hold;

endmodule
